fpga_clk_div_gen: RTL and testbench

FPGA_CLK_DIV_GEN -- requirements
Module: fpga_clk_div_gen

---
 rtl/fpga_clk_div_pkg.sv | 13 +
 rtl/fpga_clk_div_ch.sv | 79 +++++++
 rtl/fpga_clk_div_gen.sv | 46 ++++
 tb/tb_fpga_clk_div_gen.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/fpga_clk_div_pkg.sv
// Shared types and constants for the multi-channel reference-clock divider.
package fpga_clk_div_pkg;

  typedef enum logic [1:0] {
    STOPPED,
    RUNNING,
    DRAINING
  } ch_state_e;

  // Ratios below this run as this value so every clock has a high and a low phase.
  localparam int MIN_DIV = 2;

endpackage

// File: rtl/fpga_clk_div_ch.sv
// One divided-clock channel: run/drain FSM, period counter, active and pending ratio.
module fpga_clk_div_ch
  import fpga_clk_div_pkg::*;
#(
  parameter int DIV_WIDTH = 16,
  parameter int RESET_DIV = 4
) (
  input  logic                 ref_clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 load,
  input  logic [DIV_WIDTH-1:0] load_div,
  output logic                 div_clk,
  output logic                 busy
);

  ch_state_e            state, state_n;
  logic [DIV_WIDTH-1:0] cnt, cnt_n;
  logic [DIV_WIDTH-1:0] div_q, pending;
  logic [DIV_WIDTH-1:0] d_eff, half;
  logic                 clk_q, clk_n;
  logic                 at_last, apply;

  assign d_eff   = (div_q < DIV_WIDTH'(MIN_DIV)) ? DIV_WIDTH'(MIN_DIV) : div_q;
  assign half    = d_eff >> 1;
  assign at_last = (cnt == d_eff - DIV_WIDTH'(1));

  // Ratio changes only land on a period boundary (or while stopped), so no pulse is ever cut short.
  assign apply = busy && ((state == STOPPED) || at_last);

  always_ff @(posedge ref_clk or posedge rst) begin
    if (rst) begin
      state <= STOPPED;
      cnt   <= '0;
      clk_q <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      clk_q <= clk_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    clk_n   = 1'b0;
    case (state)
      STOPPED: begin
        cnt_n = '0;
        if (en) state_n = RUNNING;
      end
      RUNNING, DRAINING: begin
        clk_n = (cnt < half);
        cnt_n = at_last ? '0 : cnt + DIV_WIDTH'(1);
        if (en)           state_n = RUNNING;
        else if (at_last) state_n = STOPPED;
        else              state_n = DRAINING;
      end
      default: state_n = STOPPED;
    endcase
  end

  always_ff @(posedge ref_clk or posedge rst) begin
    if (rst) begin
      div_q   <= DIV_WIDTH'(RESET_DIV);
      pending <= '0;
      busy    <= 1'b0;
    end else if (apply) begin
      div_q <= pending;
      busy  <= 1'b0;
    end else if (load) begin
      pending <= load_div;
      busy    <= 1'b1;
    end
  end

  assign div_clk = clk_q;

endmodule

// File: rtl/fpga_clk_div_gen.sv
// Bank of independent divided clocks from ref_clk_i with a valid/ready ratio update port.
module fpga_clk_div_gen
  import fpga_clk_div_pkg::*;
#(
  parameter int NUM_CH    = 2,
  parameter int DIV_WIDTH = 16,
  parameter int RESET_DIV = 4
) (
  input  logic                                       ref_clk_i,
  input  logic                                       rst_i,
  input  logic                                       cfg_valid_i,
  output logic                                       cfg_ready_o,
  input  logic [$clog2(NUM_CH > 1 ? NUM_CH : 2)-1:0] cfg_ch_i,
  input  logic [DIV_WIDTH-1:0]                       cfg_div_i,
  input  logic [NUM_CH-1:0]                          ch_en_i,
  output logic [NUM_CH-1:0]                          clk_o,
  output logic [NUM_CH-1:0]                          busy_o
);

  localparam int CH_W    = $clog2(NUM_CH > 1 ? NUM_CH : 2);
  localparam int CH_SPAN = 2 ** CH_W;

  // Nonexistent channels read as never busy, so their requests complete and are dropped.
  logic [CH_SPAN-1:0] busy_ext;
  logic               accept;

  assign busy_ext    = CH_SPAN'(busy_o);
  assign cfg_ready_o = !busy_ext[cfg_ch_i];
  assign accept      = cfg_valid_i && cfg_ready_o;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    fpga_clk_div_ch #(
      .DIV_WIDTH(DIV_WIDTH),
      .RESET_DIV(RESET_DIV)
    ) u_ch (
      .ref_clk (ref_clk_i),
      .rst     (rst_i),
      .en      (ch_en_i[c]),
      .load    (accept && (cfg_ch_i == CH_W'(c))),
      .load_div(cfg_div_i),
      .div_clk (clk_o[c]),
      .busy    (busy_o[c])
    );
  end

endmodule

// File: tb/tb_fpga_clk_div_gen.sv
// Directed bench for fpga_clk_div_gen; expected waveforms are hand-derived bit patterns.
module tb_fpga_clk_div_gen;

  logic        ref_clk_i = 1'b0;
  logic        rst_i;
  logic        cfg_valid_i;
  logic        cfg_ready_o;
  logic [1:0]  cfg_ch_i;
  logic [15:0] cfg_div_i;
  logic [2:0]  ch_en_i;
  logic [2:0]  clk_o;
  logic [2:0]  busy_o;

  int          errors = 0;
  int          checks = 0;
  logic [15:0] clk_pat;
  logic [15:0] busy_pat;
  logic [2:0]  seen;

  // Three channels so that a 2-bit channel index can address a nonexistent channel.
  fpga_clk_div_gen #(
    .NUM_CH   (3),
    .DIV_WIDTH(16),
    .RESET_DIV(4)
  ) dut (
    .ref_clk_i  (ref_clk_i),
    .rst_i      (rst_i),
    .cfg_valid_i(cfg_valid_i),
    .cfg_ready_o(cfg_ready_o),
    .cfg_ch_i   (cfg_ch_i),
    .cfg_div_i  (cfg_div_i),
    .ch_en_i    (ch_en_i),
    .clk_o      (clk_o),
    .busy_o     (busy_o)
  );

  always #5 ref_clk_i = ~ref_clk_i;

  task automatic tick();
    @(posedge ref_clk_i);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic record();
    clk_pat  = {clk_pat[14:0], clk_o[0]};
    busy_pat = {busy_pat[14:0], busy_o[0]};
  endtask

  task automatic clear_record();
    clk_pat  = '0;
    busy_pat = '0;
    seen     = '0;
  endtask

  initial begin
    rst_i       = 1'b1;
    cfg_valid_i = 1'b0;
    cfg_ch_i    = 2'd0;
    cfg_div_i   = 16'd0;
    ch_en_i     = 3'b000;
    tick();
    tick();
    check_output("reset_clk", 32'(clk_o), 32'h0);
    check_output("reset_busy", 32'(busy_o), 32'h0);
    check_output("reset_ready", 32'(cfg_ready_o), 32'h1);

    $display("[TB] enable channel 0 at reset release, ratio 4");
    rst_i   = 1'b0;
    ch_en_i = 3'b001;
    clear_record();
    for (int i = 0; i < 8; i++) begin
      tick();
      record();
      seen = seen | {clk_o[2:1], 1'b0};
    end
    check_output("enable_d4_pattern", 32'(clk_pat), 32'h0066);
    check_output("idle_channels_low", 32'(seen), 32'h0);

    $display("[TB] ratio 7 accepted mid-period");
    tick();
    cfg_valid_i = 1'b1;
    cfg_ch_i    = 2'd0;
    cfg_div_i   = 16'd7;
    check_output("ready_idle", 32'(cfg_ready_o), 32'h1);
    clear_record();
    for (int i = 0; i < 12; i++) begin
      tick();
      record();
      if (i == 0) begin
        check_output("ready_after_accept", 32'(cfg_ready_o), 32'h0);
        cfg_valid_i = 1'b0;
      end
    end
    check_output("d4_to_d7_clk", 32'(clk_pat), 32'h0CE1);
    check_output("d4_to_d7_busy", 32'(busy_pat), 32'h0E00);

    $display("[TB] second request while busy waits for apply");
    cfg_valid_i = 1'b1;
    cfg_div_i   = 16'd5;
    tick();
    cfg_div_i = 16'd6;
    check_output("ready_blocked", 32'(cfg_ready_o), 32'h0);
    clear_record();
    for (int i = 0; i < 16; i++) begin
      tick();
      record();
      if (i == 4) check_output("ready_after_apply", 32'(cfg_ready_o), 32'h1);
      if (i == 5) cfg_valid_i = 1'b0;
    end
    check_output("back_to_back_busy", 32'(busy_pat), 32'hF780);
    check_output("back_to_back_clk", 32'(clk_pat), 32'h8638);

    $display("[TB] drain with ratio 6, then re-enable while draining");
    clear_record();
    for (int i = 0; i < 10; i++) begin
      tick();
      record();
      if (i == 0) ch_en_i = 3'b000;
    end
    check_output("drain_to_stop", 32'(clk_pat), 32'h0380);
    ch_en_i = 3'b001;
    clear_record();
    for (int i = 0; i < 12; i++) begin
      tick();
      record();
      if (i == 2) ch_en_i = 3'b000;
      if (i == 3) ch_en_i = 3'b001;
    end
    check_output("reenable_in_drain", 32'(clk_pat), 32'h071C);

    $display("[TB] ratios 0 and 1 run as 2");
    cfg_valid_i = 1'b1;
    cfg_div_i   = 16'd0;
    clear_record();
    for (int i = 0; i < 12; i++) begin
      tick();
      record();
      if (i == 0) cfg_valid_i = 1'b0;
    end
    check_output("div0_clk", 32'(clk_pat), 32'h0715);
    cfg_valid_i = 1'b1;
    cfg_div_i   = 16'd1;
    clear_record();
    for (int i = 0; i < 6; i++) begin
      tick();
      record();
      if (i == 0) cfg_valid_i = 1'b0;
    end
    check_output("div1_clk", 32'(clk_pat), 32'h0015);
    check_output("div1_busy", 32'(busy_pat), 32'h0030);

    $display("[TB] request to nonexistent channel 3");
    cfg_valid_i = 1'b1;
    cfg_ch_i    = 2'd3;
    cfg_div_i   = 16'd9;
    check_output("oor_ready", 32'(cfg_ready_o), 32'h1);
    clear_record();
    for (int i = 0; i < 4; i++) begin
      tick();
      record();
      seen = seen | busy_o;
      if (i == 0) begin
        cfg_valid_i = 1'b0;
        check_output("oor_ready_after", 32'(cfg_ready_o), 32'h1);
      end
    end
    check_output("oor_no_busy", 32'(seen), 32'h0);
    check_output("oor_clk_unchanged", 32'(clk_pat), 32'h0005);
    cfg_ch_i = 2'd0;

    $display("[TB] asynchronous reset with a pending ratio");
    cfg_valid_i = 1'b1;
    cfg_div_i   = 16'd8;
    tick();
    cfg_valid_i = 1'b0;
    tick();
    check_output("pre_reset_clk_high", 32'(clk_o[0]), 32'h1);
    check_output("pre_reset_busy", 32'(busy_o[0]), 32'h1);
    #2;
    rst_i = 1'b1;
    #1;
    check_output("async_reset_clk", 32'(clk_o), 32'h0);
    check_output("async_reset_busy", 32'(busy_o), 32'h0);
    check_output("async_reset_ready", 32'(cfg_ready_o), 32'h1);
    tick();
    check_output("held_reset_clk", 32'(clk_o), 32'h0);
    rst_i = 1'b0;
    clear_record();
    for (int i = 0; i < 8; i++) begin
      tick();
      record();
      seen = seen | busy_o;
    end
    check_output("post_reset_d4", 32'(clk_pat), 32'h0066);
    check_output("post_reset_no_busy", 32'(seen), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
